// File: rtl/fetch_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// =============================================================================
// fetch_ctrl : IF-stage fetch sequencer (PC select, imem handshake, decode hand-off)
// Optional perf counters via FETCH_CTRL_PERF_EN.   Revision: 1.0
// =============================================================================
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [31:0] i_pc,
   input  logic [31:0] i_inc_pc,
   output logic [31:0] o_next_pc,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_ready,
   input  logic        i_imem_rvalid,
   input  logic [31:0] i_imem_rdata,
   output logic        o_inst_valid,
   output logic [31:0] o_inst,
   output logic [31:0] o_inst_pc,
   input  logic        i_id_ready,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   input  logic        i_halt,
   output logic        o_halted
`ifdef FETCH_CTRL_PERF_EN
   ,
   output logic [31:0] o_fetch_cnt,
   output logic [15:0] o_kill_cnt
`endif
);

   typedef enum logic [2:0] {
      BOOT = 3'd0,
      REQ  = 3'd1,
      WAIT = 3'd2,
      HOLD = 3'd3,
      DROP = 3'd4,
      HALT = 3'd5
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] inst_pc_q, inst_pc_d;
   logic        redir_active;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q   <= BOOT;
         inst_q    <= '0;
         inst_pc_q <= '0;
      end else begin
         state_q   <= state_d;
         inst_q    <= inst_d;
         inst_pc_q <= inst_pc_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      inst_d       = inst_q;
      inst_pc_d    = inst_pc_q;
      o_next_pc    = i_pc;
      redir_active = i_redirect && (state_q inside {REQ, WAIT, HOLD, DROP});
      case (state_q)
         BOOT: begin
            o_next_pc = RESET_PC;
            state_d   = REQ;
         end
         REQ: begin
            // An accepted request under redirect is stale and must be drained.
            if (i_imem_ready) state_d = i_redirect ? DROP : WAIT;
         end
         WAIT: begin
            if (i_imem_rvalid) begin
               if (i_redirect) begin
                  state_d = REQ;
               end else begin
                  inst_d    = i_imem_rdata;
                  inst_pc_d = i_pc;
                  state_d   = HOLD;
               end
            end else if (i_redirect) begin
               state_d = DROP;
            end
         end
         HOLD: begin
            if (i_redirect) begin
               state_d = REQ;
            end else if (i_id_ready) begin
               o_next_pc = i_inc_pc;
               state_d   = i_halt ? HALT : REQ;
            end
         end
         DROP: begin
            if (i_imem_rvalid) state_d = REQ;
         end
         HALT: state_d = HALT;
         default: state_d = BOOT;
      endcase
      if (redir_active) o_next_pc = {i_redirect_pc[31:2], 2'b00};
   end

   assign o_imem_req   = (state_q == REQ);
   assign o_imem_addr  = i_pc;
   assign o_inst_valid = (state_q == HOLD);
   assign o_inst       = inst_q;
   assign o_inst_pc    = inst_pc_q;
   assign o_halted     = (state_q == HALT);

`ifdef FETCH_CTRL_PERF_EN
   logic [31:0] fetch_cnt_q;
   logic [15:0] kill_cnt_q;
   logic        handshake;
   logic        discard;

   assign handshake = (state_q == HOLD) && i_id_ready;
   assign discard   = i_imem_rvalid &&
                      ((state_q == DROP) || ((state_q == WAIT) && i_redirect));

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         fetch_cnt_q <= '0;
         kill_cnt_q  <= '0;
      end else begin
         if (handshake) fetch_cnt_q <= fetch_cnt_q + 32'd1;
         if (discard && (kill_cnt_q != 16'hFFFF)) kill_cnt_q <= kill_cnt_q + 16'd1;
      end
   end

   assign o_fetch_cnt = fetch_cnt_q;
   assign o_kill_cnt  = kill_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// =============================================================================
// tb_fetch_ctrl : scoreboard bench for fetch_ctrl with a PC register and imem model
// Revision: 1.0
// =============================================================================
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] pc_q;
   logic [31:0] next_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        rvalid;
   logic [31:0] rdata;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        id_ready;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        halt;
   logic        halted;
`ifdef FETCH_CTRL_PERF_EN
   logic [31:0] fetch_cnt;
   logic [15:0] kill_cnt;
`endif

   int          n_checks = 0;
   int          n_fail   = 0;
   int          mem_lat  = 1;
   logic        pend;
   logic        pkill;
   int          cnt;
   logic [31:0] paddr;
   logic [63:0] sb[$];

   always #5 clk = ~clk;

   fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_pc         (pc_q),
      .i_inc_pc     (pc_q + 32'd4),
      .o_next_pc    (next_pc),
      .o_imem_req   (imem_req),
      .o_imem_addr  (imem_addr),
      .i_imem_ready (imem_ready),
      .i_imem_rvalid(rvalid),
      .i_imem_rdata (rdata),
      .o_inst_valid (inst_valid),
      .o_inst       (inst),
      .o_inst_pc    (inst_pc),
      .i_id_ready   (id_ready),
      .i_redirect   (redirect),
      .i_redirect_pc(redirect_pc),
      .i_halt       (halt),
      .o_halted     (halted)
`ifdef FETCH_CTRL_PERF_EN
      ,
      .o_fetch_cnt  (fetch_cnt),
      .o_kill_cnt   (kill_cnt)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h8)      return 32'h0050_0093;
      else if (a == 32'hC) return 32'hDEAD_BEEF;
      else                 return {~a[15:0], a[15:0]};
   endfunction

   // PC register: loads next_pc every edge.
   always @(posedge clk) pc_q <= next_pc;

   // Memory model; expected deliveries enter the scoreboard on acceptance
   // and are withdrawn again when a redirect kills the outstanding fetch.
   always @(posedge clk) begin
      if (!rst_n) begin
         pend  <= 1'b0;
         pkill <= 1'b0;
         cnt   <= 0;
         sb.delete();
      end else if (imem_req && imem_ready) begin
         pend  <= 1'b1;
         cnt   <= mem_lat;
         paddr <= imem_addr;
         pkill <= redirect;
         if (!redirect) sb.push_back({imem_addr, mem_word(imem_addr)});
      end else if (pend) begin
         if (redirect && !pkill) begin
            void'(sb.pop_back());
            pkill <= 1'b1;
         end
         if (cnt == 1) pend <= 1'b0;
         else          cnt  <= cnt - 1;
      end
   end

   assign rvalid = pend && (cnt == 1);
   assign rdata  = rvalid ? mem_word(paddr) : 32'h0;

   // Consumer side of the scoreboard.
   always @(negedge clk) begin
      logic [63:0] e;
      if (rst_n && inst_valid) begin
         if (id_ready) begin
            check("sb_depth", 32'(sb.size()), 32'd1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               check("sb_inst_pc", inst_pc, e[63:32]);
               check("sb_inst", inst, e[31:0]);
            end
         end else if (redirect && sb.size() > 0) begin
            void'(sb.pop_front());
         end
      end
   end

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   logic imem_ready_en;
   assign imem_ready = imem_ready_en;

   initial begin
      rst_n = 1'b0; imem_ready_en = 1'b1; id_ready = 1'b1;
      redirect = 1'b0; redirect_pc = 32'h0; halt = 1'b0;
      repeat (3) cyc();
      #2;
      check("rst_req", {31'd0, imem_req}, 32'd0);
      check("rst_valid", {31'd0, inst_valid}, 32'd0);
      check("rst_inst", inst, 32'd0);
      check("rst_inst_pc", inst_pc, 32'd0);
      check("rst_halted", {31'd0, halted}, 32'd0);
      check("rst_next_pc", next_pc, 32'd0);

      cyc(); rst_n = 1'b1; #2;
      check("boot_next_pc", next_pc, 32'd0);

      // Streaming: REQ, WAIT, HOLD repeated; stall decode on the third.
      for (int k = 0; k < 9; k++) begin
         cyc();
         id_ready = (k != 8);
         #2;
         check("seq_req", {31'd0, imem_req}, {31'd0, (k % 3 == 0)});
         check("seq_valid", {31'd0, inst_valid}, {31'd0, (k % 3 == 2)});
         if (k % 3 == 0) check("seq_addr", imem_addr, 32'(4 * (k / 3)));
         if (k % 3 == 2) check("seq_inst_pc", inst_pc, 32'(4 * (k / 3)));
      end

      for (int k = 0; k < 5; k++) begin
         cyc(); #2;
         check("stall_inst", inst, 32'h0050_0093);
         check("stall_inst_pc", inst_pc, 32'h8);
         check("stall_req", {31'd0, imem_req}, 32'd0);
         check("stall_next_pc", next_pc, 32'h8);
      end
      cyc(); id_ready = 1'b1; mem_lat = 3; #2;
      check("release_next_pc", next_pc, 32'hC);

      // Redirect while waiting; stale 0xDEADBEEF response must be dropped.
      cyc(); #2;
      check("drop_req_addr", imem_addr, 32'hC);
      cyc(); redirect = 1'b1; redirect_pc = 32'h103; mem_lat = 1; #2;
      check("drop_next_pc", next_pc, 32'h100);
      check("drop_wait_req", {31'd0, imem_req}, 32'd0);
      cyc(); redirect = 1'b0; #2;
      check("drop_valid0", {31'd0, inst_valid}, 32'd0);
      check("drop_req0", {31'd0, imem_req}, 32'd0);
      cyc(); #2;
      check("drop_valid1", {31'd0, inst_valid}, 32'd0);
      check("drop_req1", {31'd0, imem_req}, 32'd0);
      cyc(); #2;
      check("target_req", {31'd0, imem_req}, 32'd1);
      check("target_addr", imem_addr, 32'h100);
`ifdef FETCH_CTRL_PERF_EN
      check("kill_cnt", {16'd0, kill_cnt}, 32'd1);
`endif

      // Redirect in HOLD with id_ready and halt: redirect wins.
      cyc(); #2;
      cyc(); redirect = 1'b1; redirect_pc = 32'h40; halt = 1'b1; #2;
      check("hold_valid", {31'd0, inst_valid}, 32'd1);
      check("hold_redir_pc", next_pc, 32'h40);

      // Memory not ready for 10 cycles.
      cyc(); redirect = 1'b0; halt = 1'b0; imem_ready_en = 1'b0; #2;
      check("redir_halted", {31'd0, halted}, 32'd0);
      for (int k = 0; k < 10; k++) begin
         if (k != 0) begin cyc(); #2; end
         check("nrdy_req", {31'd0, imem_req}, 32'd1);
         check("nrdy_addr", imem_addr, 32'h40);
         check("nrdy_next_pc", next_pc, 32'h40);
      end
      cyc(); imem_ready_en = 1'b1; #2;
      check("rdy_req", {31'd0, imem_req}, 32'd1);
      cyc(); #2;
      cyc(); halt = 1'b1; #2;
      check("halt_inst_pc", inst_pc, 32'h40);
      check("halt_next_pc", next_pc, 32'h44);

      // Halted: no requests, redirect ignored.
      cyc(); halt = 1'b0; #2;
      check("halted", {31'd0, halted}, 32'd1);
`ifdef FETCH_CTRL_PERF_EN
      check("fetch_cnt", fetch_cnt, 32'd5);
`endif
      for (int k = 0; k < 20; k++) begin
         cyc();
         redirect = (k == 5); redirect_pc = 32'h200;
         #2;
         check("halt_req", {31'd0, imem_req}, 32'd0);
         check("halt_hold", {31'd0, halted}, 32'd1);
         check("halt_pc", next_pc, 32'h44);
      end
      redirect = 1'b0;

      cyc(); rst_n = 1'b0; #2;
      cyc(); rst_n = 1'b1; #2;
      check("rerst_halted", {31'd0, halted}, 32'd0);
      check("rerst_next_pc", next_pc, 32'd0);
      check("rerst_valid", {31'd0, inst_valid}, 32'd0);
`ifdef FETCH_CTRL_PERF_EN
      check("rerst_fetch_cnt", fetch_cnt, 32'd0);
`endif
      cyc(); #2;
      check("rerst_req", {31'd0, imem_req}, 32'd1);
      check("rerst_addr", imem_addr, 32'd0);
      repeat (4) cyc();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
